// File: rtl/dz_pkg.sv
// Shared types, glyph ROM and helpers for the bicolour 8x8 countdown display.
// Row 0 of each glyph is the top line; bit 7 is the leftmost column.
package dz_pkg;

    localparam int NUM_ROWS    = 8;
    localparam int FONT_DIGITS = 10;

    typedef enum logic [1:0] {
        COL_OFF = 2'b00,
        COL_R   = 2'b01,
        COL_G   = 2'b10,
        COL_Y   = 2'b11
    } color_e;

    typedef struct packed {
        logic [3:0] num;
        color_e     color;
        logic       blink_en;
    } disp_cfg_t;

    localparam logic [7:0] FONT_0_9 [FONT_DIGITS][NUM_ROWS] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };

    // Row select pattern for one selected row; act_low inverts for sink drivers.
    function automatic logic [7:0] row_onehot(input logic [2:0] idx, input logic act_low);
        logic [7:0] hot;
        hot = 8'h01 << idx;
        return act_low ? ~hot : hot;
    endfunction

endpackage

// File: rtl/dz_row_scanner.sv
// Row slot timer: divides clk into SCAN_DIV-cycle slots, walks rows 0..7
// and flags the anti-ghost blanking window and the frame boundary.
module dz_row_scanner
    import dz_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] row_idx,
    output logic       slot_blank,
    output logic       frame_tick,
    output logic       frame_done
);

    localparam int               DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [2:0]       ROW_LAST  = 3'(NUM_ROWS - 1);

    logic [DIV_W-1:0] div;
    logic             div_last;

    assign div_last   = (div == DIV_LAST);
    assign frame_tick = div_last && (row_idx == ROW_LAST);
    assign slot_blank = (div < BLANK_END);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            row_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_tick;
            if (div_last) begin
                div     <= '0;
                row_idx <= row_idx + 3'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/dz_scan_display.sv
// 8x8 red/green dot-matrix driver: frame-synchronous value update, blink,
// font lookup and registered row/column outputs.
module dz_scan_display
    import dz_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int MAX_DIGIT    = 9,
    parameter int ROW_ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic [1:0] color,
    input  logic       blink_en,
    input  logic       load,
    output logic [7:0] row,
    output logic [7:0] colr,
    output logic [7:0] colg,
    output logic       frame_done
);

    localparam int         FC_W     = $clog2(BLINK_FRAMES) + 1;
    localparam logic       ACT_LOW  = (ROW_ACT_LOW != 0);
    localparam logic [7:0] ROW_IDLE = ACT_LOW ? 8'hFF : 8'h00;

    logic [2:0] row_idx;
    logic       slot_blank;
    logic       frame_tick;

    dz_row_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .row_idx    (row_idx),
        .slot_blank (slot_blank),
        .frame_tick (frame_tick),
        .frame_done (frame_done)
    );

    disp_cfg_t load_cfg;
    disp_cfg_t pending;
    disp_cfg_t active;

    assign load_cfg = '{num: num, color: color_e'(color), blink_en: blink_en};

    // A load coinciding with the frame edge bypasses pending so it is not a frame late.
    // NOTE: every register here is reset; the glyph ROM is a constant table and
    // holds no state, so nothing memory-like is left undefined after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (load) begin
                pending <= load_cfg;
            end
            if (frame_tick) begin
                active <= load ? load_cfg : pending;
            end
        end
    end

    logic [FC_W-1:0] frame_cnt;
    logic            blink_on;

    // Free-running blink timebase; blink_en only gates the glyph, never the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    logic [7:0] glyph;
    logic       glyph_vis;
    logic       red_en;
    logic       green_en;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        glyph     = 8'h00;
        glyph_vis = (int'(active.num) <= MAX_DIGIT)
                 && (active.num < 4'(FONT_DIGITS))
                 && (!active.blink_en || blink_on);
        red_en    = (active.color == COL_R) || (active.color == COL_Y);
        green_en  = (active.color == COL_G) || (active.color == COL_Y);
        if (glyph_vis) begin
            glyph = FONT_0_9[active.num][row_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= ROW_IDLE;
            colr <= 8'h00;
            colg <= 8'h00;
        end else begin
            row  <= row_onehot(row_idx, ACT_LOW);
            colr <= slot_blank ? 8'h00 : (glyph & {8{red_en}});
            colg <= slot_blank ? 8'h00 : (glyph & {8{green_en}});
        end
    end

endmodule

// File: tb/tb_dz_scan_display.sv
// Scoreboard bench for dz_scan_display: the stimulus pushes one expected
// frame per boundary, a monitor checks every output cycle of that frame.
module tb_dz_scan_display;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int MAX_DIGIT    = 9;
    localparam int ROW_ACT_LOW  = 1;
    localparam int FRAME_CYC    = SCAN_DIV * 8;

    typedef struct packed {
        logic [7:0][7:0] r;
        logic [7:0][7:0] g;
    } frame_exp_t;

    localparam logic [7:0] FONT [10][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] num = 4'd0;
    logic [1:0] color = 2'b00;
    logic       blink_en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       frame_done;

    always #5 clk = ~clk;

    dz_scan_display #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES),
        .MAX_DIGIT    (MAX_DIGIT),
        .ROW_ACT_LOW  (ROW_ACT_LOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .num        (num),
        .color      (color),
        .blink_en   (blink_en),
        .load       (load),
        .row        (row),
        .colr       (colr),
        .colg       (colg),
        .frame_done (frame_done)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    frame_exp_t sb_q[$];

    // Reference model state: pending/active settings and the blink timebase.
    logic [3:0] m_pn, m_an;
    logic [1:0] m_pc, m_ac;
    logic       m_pb, m_ab;
    int         m_cnt;
    logic       m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pn = 4'd0; m_pc = 2'b00; m_pb = 1'b0;
        m_an = 4'd0; m_ac = 2'b00; m_ab = 1'b0;
        m_cnt = 0;
        m_phase = 1'b1;
    endtask

    function automatic frame_exp_t make_exp();
        frame_exp_t e;
        logic [7:0] gl;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            gl = 8'h00;
            if (int'(m_an) <= MAX_DIGIT && (!m_ab || m_phase)) gl = FONT[m_an][i];
            e.r[i] = m_ac[0] ? gl : 8'h00;
            e.g[i] = m_ac[1] ? gl : 8'h00;
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s row", tag), row, 8'hFF);
        check($sformatf("%s colr", tag), colr, 8'h00);
        check($sformatf("%s colg", tag), colg, 8'h00);
        check($sformatf("%s frame_done", tag), frame_done, 1'b0);
    endtask

    // Runs one frame, starting right after a frame_done sample (or reset release).
    // Optional mid-frame load (a decoy then the real value) and optional load on
    // the boundary edge; pushes the expected picture of the following frame.
    task automatic run_frame(input bit do_mid, input logic [3:0] mn, input logic [1:0] mc,
                             input logic mb, input bit do_edge, input logic [3:0] en,
                             input logic [1:0] ec, input logic eb, input string tag);
        int early = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done) early++;
        end
        if (do_mid) begin
            num = ~mn; color = ~mc; blink_en = ~mb; load = 1'b1;
        end
        @(negedge clk);
        if (frame_done) early++;
        if (do_mid) begin
            num = mn; color = mc; blink_en = mb;
            m_pn = mn; m_pc = mc; m_pb = mb;
        end
        @(negedge clk);
        if (frame_done) early++;
        load = 1'b0;

        if (do_edge) begin
            m_pn = en; m_pc = ec; m_pb = eb;
        end
        m_an = m_pn; m_ac = m_pc; m_ab = m_pb;
        if (m_cnt == BLINK_FRAMES - 1) begin
            m_cnt = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
        sb_q.push_back(make_exp());

        repeat (19) begin
            @(negedge clk);
            if (frame_done) early++;
        end
        if (do_edge) begin
            num = en; color = ec; blink_en = eb; load = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        check($sformatf("%s frame_done early", tag), early, 0);
        check($sformatf("%s frame_done on time", tag), frame_done, 1'b1);
    endtask

    // Monitor: checks {row, colr, colg} on every cycle of each expected frame.
    initial begin
        frame_exp_t cur;
        bit         have = 1'b0;
        int         pos = 0;
        int         frame_no = 0;
        int         r;
        logic [7:0] er, ecr, ecg;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 1'b0;
                sb_q.delete();
            end else begin
                if (have) begin
                    r  = pos / SCAN_DIV;
                    er = 8'hFF;
                    er[r] = 1'b0;
                    ecr = ((pos % SCAN_DIV) < BLANK_CYC) ? 8'h00 : cur.r[r];
                    ecg = ((pos % SCAN_DIV) < BLANK_CYC) ? 8'h00 : cur.g[r];
                    check($sformatf("scan frame %0d cycle %0d row/colr/colg", frame_no, pos),
                          {8'h00, row, colr, colg}, {8'h00, er, ecr, ecg});
                    pos++;
                    if (pos == FRAME_CYC) have = 1'b0;
                end
                if (frame_done && sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    have = 1'b1;
                    pos = 0;
                    frame_no++;
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset immediate");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset held");
        rst = 1'b0;
        model_reset();

        run_frame(0, 4'd0, 2'b00, 0, 0, 4'd0, 2'b00, 0, "t1 first frame");
        run_frame(1, 4'd5, 2'b01, 0, 0, 4'd0, 2'b00, 0, "t2 load 5 red");
        run_frame(1, 4'd8, 2'b11, 0, 0, 4'd0, 2'b00, 0, "t3 load 8 yellow");
        run_frame(1, 4'd12, 2'b10, 0, 0, 4'd0, 2'b00, 0, "t4 load 12");
        run_frame(0, 4'd0, 2'b00, 0, 0, 4'd0, 2'b00, 0, "t4 hold");
        run_frame(1, 4'd3, 2'b01, 1, 0, 4'd0, 2'b00, 0, "t5 blink 3");
        for (int k = 0; k < 5; k++) begin
            run_frame(0, 4'd0, 2'b00, 0, 0, 4'd0, 2'b00, 0, $sformatf("t5 blink run %0d", k));
        end
        run_frame(1, 4'd2, 2'b01, 0, 1, 4'd7, 2'b10, 0, "t6 edge load 7");
        run_frame(0, 4'd0, 2'b00, 0, 0, 4'd0, 2'b00, 0, "t6 hold");

        // Now inside a frame showing green 7; go to the second cycle of row 4.
        repeat (18) @(negedge clk);
        check("pre-reset row", row, 8'hEF);
        check("pre-reset colg", colg, FONT[7][4]);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid-row reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("mid-row reset held");
        rst = 1'b0;
        model_reset();

        run_frame(0, 4'd0, 2'b00, 0, 0, 4'd0, 2'b00, 0, "t7 post-reset blank");
        run_frame(1, 4'd0, 2'b01, 0, 0, 4'd0, 2'b00, 0, "t7 load 0 red");
        run_frame(0, 4'd0, 2'b00, 0, 0, 4'd0, 2'b00, 0, "t7 hold");
        repeat (FRAME_CYC + 1) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
